// File: rtl/vga_pkg.sv
// VGA 640x480@60 timing constants and coordinate type shared by the sync generator.
package vga_pkg;
  localparam int CLK_DIV  = 4;
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;
  localparam bit SYNC_POL = 1'b0;
  localparam int COORD_W  = 10;

  typedef logic [COORD_W-1:0] coord_t;

  function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction
endpackage

// File: rtl/vga_pix_tick.sv
// Pixel-rate enable: one-cycle tick every CLK_DIV clk_i cycles, asserted on the
// last cycle of each pixel period; no derived clock.
module vga_pix_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (cnt_q == CNT_LAST) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == CNT_LAST);
endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: h/v counters advanced by the pixel tick, with every output
// registered once so all of them lag the counters by exactly one clk_i.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = vga_pkg::CLK_DIV,
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP,
  parameter bit SYNC_POL = vga_pkg::SYNC_POL
) (
  input  logic         clk_i,
  input  logic         rst_i,
  output logic         hsync_o,
  output logic         vsync_o,
  output logic         video_on_o,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic         pix_tick_o,
  output logic         frame_start_o
);
  localparam coord_t H_LAST = coord_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam coord_t V_LAST = coord_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam coord_t H_ACT  = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT  = coord_t'(V_ACTIVE);
  localparam coord_t HS_LO  = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_HI  = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam coord_t VS_LO  = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_HI  = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic   tick;
  coord_t h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  coord_t x_d, y_d;
  logic   hsync_d, vsync_d, video_on_d, pix_tick_d, frame_start_d;

  vga_pix_tick #(.CLK_DIV(CLK_DIV)) u_pix_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .tick_o (tick)
  );

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (tick) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + coord_t'(1);
      end else begin
        h_cnt_d = h_cnt_q + coord_t'(1);
      end
    end
  end

  // Output decode works on the current counters; the register below adds the one-cycle lag.
  always_comb begin
    x_d           = h_cnt_q;
    y_d           = v_cnt_q;
    pix_tick_d    = tick;
    video_on_d    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    frame_start_d = tick && (h_cnt_q == '0) && (v_cnt_q == '0);
    hsync_d       = in_window(h_cnt_q, HS_LO, HS_HI) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = in_window(v_cnt_q, VS_LO, VS_HI) ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      x_o           <= '0;
      y_o           <= '0;
      pix_tick_o    <= 1'b0;
      video_on_o    <= 1'b0;
      frame_start_o <= 1'b0;
      hsync_o       <= ~SYNC_POL;
      vsync_o       <= ~SYNC_POL;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      x_o           <= x_d;
      y_o           <= y_d;
      pix_tick_o    <= pix_tick_d;
      video_on_o    <= video_on_d;
      frame_start_o <= frame_start_d;
      hsync_o       <= hsync_d;
      vsync_o       <= vsync_d;
    end
  end
endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

VGA 640x480@60 timing generator for the BASYS 3 design, running entirely in the 100 MHz system clock domain. It is the consumer end of the 25 MHz pixel-rate divider: it counts pixel periods with a single-cycle pixel-tick enable, not a divided clock, and produces HSYNC/VSYNC, the active-video flag and pixel coordinates. Those outputs drive the VGA connector and the downstream pixel generator.

## Interface
- CLK_DIV, 4: clk_i cycles per pixel; 100 MHz / 4 = 25 MHz.
- H_ACTIVE, 640 / H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal timing in pixels; H_TOTAL = 800.
- V_ACTIVE, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical timing in lines; V_TOTAL = 525.
- SYNC_POL, 0: sync asserted level; 0 means active-low.
- clk_i  in  1  system clock, 100 MHz. One clock; all logic on its rising edge.
- rst_i  in  1  reset. Synchronous and active-high.
- hsync_o  out  1  horizontal sync at SYNC_POL level during the sync window.
- vsync_o  out  1  vertical sync at SYNC_POL level during the sync window.
- video_on_o  out  1  high when (x_o, y_o) is inside 640x480.
- x_o  out  10  horizontal pixel count, 0..799.
- y_o  out  10  line count, 0..524.
- pix_tick_o  out  1  one-clk_i strobe marking the last clk_i cycle of each pixel period.
- frame_start_o  out  1  equals pix_tick_o while x_o = 0 and y_o = 0.

## Operation
- tick_cnt counts 0..CLK_DIV-1 and wraps. Internal tick = (tick_cnt == CLK_DIV-1).
- On tick:
  - h_cnt increments.
  - At h_cnt = H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - At v_cnt = V_TOTAL-1 with the h wrap, v_cnt wraps to 0.
  - h_cnt and v_cnt hold between ticks.
- Output stage is registered every clk_i cycle:
  - x_o <= h_cnt, y_o <= v_cnt.
  - pix_tick_o <= tick.
  - hsync_o and vsync_o are decoded from h_cnt and v_cnt.
  - video_on_o = (h_cnt < 640) && (v_cnt < 480).
  - frame_start_o = tick && h_cnt == 0 && v_cnt == 0.
- All outputs are mutually aligned.
- hsync window: x_o in [656, 751]. vsync window: y_o in [490, 491]. Outside its window, each sync sits at ~SYNC_POL.
- Counter widths: 10 bits each. Equality compares only; no arithmetic overflow is possible.
- The values in each output register are produced only by the wrap rules above; x_o never shows 800 and y_o never shows 525.

## Timing
- Reset values (next edge after rst_i = 1):
  - tick_cnt = h_cnt = v_cnt = 0.
  - x_o = y_o = 0.
  - video_on_o = 0, pix_tick_o = 0, frame_start_o = 0.
  - hsync_o = vsync_o = ~SYNC_POL (1 at default).
- Reset asserted mid-frame gives the same values on the next edge, independent of state. rst_i overrides tick.
- After release, clk_i cycles are numbered 0, 1, 2, ...
  - tick_cnt is 0, 1, 2, 3 in cycles 0..3.
  - Cycle 4: first pix_tick_o, with x_o = 0, y_o = 0, frame_start_o = 1.
- pix_tick_o is high in cycles 4 + 4k.
- x_o and y_o change in the cycle after each pix_tick_o and hold for CLK_DIV cycles.
- Periods:
  - Line: 3200 clk_i.
  - Frame: 1,680,000 clk_i.
  - hsync pulse: 384 clk_i.
  - vsync pulse: 6400 clk_i.
- Latency: outputs lag internal counters by exactly one clk_i.

## Structure
- Package vga_pkg holds the timing constants (H_*, V_*, totals, sync window bounds) and the coordinate width (10).
- Sub-module vga_pix_tick:
  - Parameterised CLK_DIV enable generator.
  - Ports clk_i, rst_i, tick_o.
  - Replaces the divided-clock approach, so there is no generated clock domain.
- vga_sync_gen instantiates vga_pix_tick and holds the h/v counters plus the output register stage.

## Test plan
- Reset, release -> pix_tick_o first high at cycle 4 with frame_start_o = 1, x_o = 0, y_o = 0; all outputs match reset values in cycles 0..3.
- Run one line -> pix_tick_o every 4 cycles; x_o runs 0..799 then wraps to 0 while y_o goes 0 -> 1; video_on_o high for exactly 640 ticks.
- Line 0 hsync -> hsync_o low exactly while x_o is in 656..751, i.e. 384 clk_i; high elsewhere.
- Full frame -> vsync_o low only for y_o in 490..491; frame_start_o pulses again exactly 1,680,000 cycles after the first.
- Assert rst_i for 1 cycle at x_o = 700, y_o = 300 -> next edge gives all reset values; frame_start_o follows 4 cycles after release.
- SYNC_POL = 1 build -> sync outputs inverted, all timing unchanged.
